fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised instruction-fetch front end that decouples instruction memory from decode through a DEPTH-entry prefetch queue. Each cycle with free space it issues one word address to the synchronous instruction memory. It predecodes each returned word to follow J/JAL, BC and backward BEQ/BNE statically, and accepts a redirect from execute that flushes all speculative state. It sits between the instruction BRAM and the decode stage, and presents a valid/ready stream of {pc, command, pred_taken}.

## Interface
- ADDR_W, 16, instruction-memory word-address width; inst_addr = pc[ADDR_W+1:2]
- DEPTH, 4, queue entries (power of two, ≥2)
- RESET_PC, 32'h0, first fetch address after reset
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- redirect  in  1  branch mispredict / jump-register; restart fetch at redirect_pc
- redirect_pc  in  32  restart address; bits [1:0] ignored
- inst_enable  out  1  memory read strobe; high when an address is issued
- inst_addr  out  ADDR_W  word address (combinational)
- inst_data  in  32  memory data, valid the cycle after inst_enable
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head
- out_pc  out  32  pc of head instruction
- out_command  out  32  head instruction word
- out_pred_taken  out  1  head was predicted taken by predecode

## Operation
- State: fetch_pc (32), inflight flag + inflight_pc, queue (DEPTH × {pc, command, pred_taken}), count (clog2(DEPTH)+1 bits).
- Issue: inst_enable = rstn & (redirect | count + inflight < DEPTH). Issued address is redirect_pc if redirect, else fetch_pc. On issue, inflight ← 1, inflight_pc ← issued pc, fetch_pc ← issued pc + 4 (mod 2^32).
- Response: when inflight, inst_data is enqueued with inflight_pc. Predecode on inst_data:
  - opcode[31:27]=00001 (J/JAL): target = {4'b0000, imm26, 2'b00}.
  - [31:26]=110010 (BC): target = inflight_pc + sext(imm26)<<2.
  - [31:27]=00010 with bit15=1 (backward BEQ/BNE): target = inflight_pc + sext(imm16)<<2.
  - Otherwise not taken.
- Taken prediction: fetch_pc ← target. The sequential fetch issued in the same cycle, which is necessarily inflight_pc+4, is squashed: its response is dropped the next cycle (1-cycle bubble). pred_taken = 1 is stored with the entry.
- Redirect: has priority over everything. Queue flushed (count ← 0), in-flight response discarded, prediction ignored, redirect_pc issued in the same cycle. out_valid is gated low during the redirect cycle, so no transfer occurs then.
- Dequeue: out_valid & out_ready pops the head. Enqueue and dequeue in the same cycle are both performed; count is unchanged.
- Reset: fetch_pc ← RESET_PC, count ← 0, inflight ← 0, squash ← 0. out_valid = 0, out_pc/out_command/out_pred_taken = 0, inst_enable = 0 while rstn = 0. Reset mid-fetch discards the pending response.

## Timing
- Fetch-to-valid latency 2: address issued in cycle t, data enqueued at the end of t+1, out_valid at t+2.
- Redirect in cycle t: target instruction on out_valid at t+2. Nothing stale is ever presented after t.
- Predicted-taken branch: target instruction appears 2 cycles after the branch entry (one bubble).
- Steady state with out_ready = 1: one instruction per cycle.
- Full: with count + inflight = DEPTH there is no issue. Issue resumes the cycle after a pop frees space (conservative, pop not forwarded).
- pc and address wrap modulo 2^32; inst_addr truncates to ADDR_W bits.

## Structure
- Package fetch_pkg holds the opcode constants (OP_J = 5'b00001, OP_BC = 6'b110010, OP_BEQNE = 5'b00010), the entry typedef {pc, command, pred_taken}, and a predecode function returning {taken, target}.
- Sub-module fetch_fifo: synchronous DEPTH × entry FIFO with push/pop/flush and count output. Flush has priority over push.

## Test plan
- Reset, then out_ready = 1 with straight-line code: inst_addr sequence 0, 1, 2, 3…; out_pc 0x0, 0x4, 0x8; first out_valid 2 cycles after reset release.
- J at pc 0x8 with imm26 = 0x40: out_pc stream 0x8 then 0x100 with one bubble; pred_taken = 1 on the 0x8 entry; the word at 0xC never appears.
- BEQ at pc 0x20 with imm16 = 0xFFFE: next out_pc 0x18. BEQ with imm16 = 0x0002: next 0x24 and pred_taken = 0.
- out_ready = 0 with DEPTH = 4: exactly 4 entries queued and inst_enable low. One pop gives exactly one new issue, and no entry is lost or duplicated.
- redirect = 1, redirect_pc = 0x1003 while the queue is full and a fetch is in flight: out_valid low that cycle, inst_addr = 0x400, next out_pc 0x1000 at t+2, no stale entries.
- Redirect coinciding with a predicted-taken J response: the redirect target wins and the J target is never fetched.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end: opcode fields the
// predecoder recognises, the queue entry layout and the static predictor.
package fetch_pkg;

    localparam logic [4:0] OP_J     = 5'b00001;   // J / JAL, bits [31:27]
    localparam logic [5:0] OP_BC    = 6'b110010;  // BC, bits [31:26]
    localparam logic [4:0] OP_BEQNE = 5'b00010;   // BEQ / BNE, bits [31:27]

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] command;
        logic        pred_taken;
    } entry_t;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } pred_t;

    // Static prediction: unconditional jumps and BC always taken, BEQ/BNE taken
    // only when the displacement is negative (loop back-edges).
    function automatic pred_t predecode(input logic [31:0] pc, input logic [31:0] word);
        pred_t p;
        p.taken  = 1'b0;
        p.target = 32'h0;
        if (word[31:27] == OP_J) begin
            p.taken  = 1'b1;
            p.target = {4'b0000, word[25:0], 2'b00};
        end else if (word[31:26] == OP_BC) begin
            p.taken  = 1'b1;
            p.target = pc + {{4{word[25]}}, word[25:0], 2'b00};
        end else if ((word[31:27] == OP_BEQNE) && word[15]) begin
            p.taken  = 1'b1;
            p.target = pc + {{14{word[15]}}, word[15:0], 2'b00};
        end
        return p;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue between memory response and decode. Power-of-two depth so the
// pointers wrap naturally; flush empties the queue and beats a same-cycle push.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    output entry_t                   head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    entry_t        mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; simultaneous push and pop keep count.
    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage, written at the tail when a push is accepted.
    always_ff @(posedge clk) begin
        if (rstn && !flush && do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues one word address per cycle while the
// queue has room, predecodes each returned word to steer fetch statically,
// and restarts cleanly on a redirect from execute.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int          ADDR_W   = 16,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic              inst_enable,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic [31:0]       inst_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_command,
    output logic              out_pred_taken
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   inflight_pc;
    logic          inflight;
    logic          squash;
    logic [31:0]   redirect_aligned;
    logic [31:0]   issue_pc;
    logic          issue;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   occupancy;
    logic          resp_valid;
    logic          taken;
    logic          pop;
    pred_t         pred;
    entry_t        push_entry;
    entry_t        head;

    // An in-flight fetch already owns a queue slot, so it counts towards
    // occupancy; a pop is not forwarded into this cycle's issue decision.
    assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;
    assign issue_pc         = redirect ? redirect_aligned : fetch_pc;
    assign occupancy        = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
    assign issue            = rstn && (redirect || (occupancy < (CW+1)'(DEPTH)));
    assign inst_enable      = issue;
    assign inst_addr        = issue_pc[ADDR_W+1:2];

    // A response is dropped when it belongs to a squashed fall-through fetch or
    // when execute is redirecting this cycle.
    assign resp_valid = inflight && !squash && !redirect;
    assign pred       = predecode(inflight_pc, inst_data);
    assign taken      = resp_valid && pred.taken;
    assign push_entry = '{pc: inflight_pc, command: inst_data, pred_taken: pred.taken};

    assign out_valid      = rstn && !redirect && (fifo_count != '0);
    assign pop            = out_valid && out_ready;
    assign out_pc         = out_valid ? head.pc : 32'h0;
    assign out_command    = out_valid ? head.command : 32'h0;
    assign out_pred_taken = out_valid && head.pred_taken;

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .flush    (redirect),
        .push     (resp_valid),
        .push_data(push_entry),
        .pop      (pop),
        .head     (head),
        .count    (fifo_count)
    );

    // Fetch pointer and in-flight tracking: redirect beats prediction, which
    // beats the sequential increment; a taken prediction squashes the
    // fall-through fetch issued alongside it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= 32'h0;
            squash      <= 1'b0;
        end else begin
            inflight <= issue;
            squash   <= issue && taken;
            if (issue) inflight_pc <= issue_pc;
            if (redirect)   fetch_pc <= redirect_aligned + 32'd4;
            else if (taken) fetch_pc <= pred.target;
            else if (issue) fetch_pc <= fetch_pc + 32'd4;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a synchronous instruction memory model,
// a table of predecode cases, and hand-written multi-cycle sequences.
module tb_fetch_queue;

    localparam int ADDR_W = 16;
    localparam int DEPTH  = 4;

    typedef struct {
        logic [31:0] br_pc;
        logic [31:0] word;
        logic        exp_taken;
        logic [31:0] exp_next;
        int          exp_gap;
    } vec_t;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              redirect = 1'b0;
    logic [31:0]       redirect_pc = 32'h0;
    logic              inst_enable;
    logic [ADDR_W-1:0] inst_addr;
    logic [31:0]       inst_data = 32'h0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       out_pc;
    logic [31:0]       out_command;
    logic              out_pred_taken;

    logic [31:0] imem [0:4095];
    int          tests_run = 0;
    int          tests_failed = 0;
    vec_t        vecs [10];
    vec_t        v;
    logic        found;
    int          gap;
    logic [31:0] next_pc;
    logic        bad_fetch;

    fetch_queue #(
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .RESET_PC(32'h0)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .inst_enable   (inst_enable),
        .inst_addr     (inst_addr),
        .inst_data     (inst_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_command   (out_command),
        .out_pred_taken(out_pred_taken)
    );

    always #5 clk = ~clk;

    // Synchronous BRAM: data for an issued address arrives the next cycle.
    always @(posedge clk) begin
        if (inst_enable) inst_data <= imem[inst_addr[11:0]];
    end

    // Inputs change at the falling edge; outputs are sampled 1 ns later.
    task automatic applyStimulus(input logic rst_v, input logic red_v,
                                 input logic [31:0] rpc_v, input logic rdy_v);
        @(negedge clk);
        rstn        = rst_v;
        redirect    = red_v;
        redirect_pc = rpc_v;
        out_ready   = rdy_v;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Default memory word is its own word index: opcode 0, never predicted.
        for (int i = 0; i < 4096; i++) imem[i] = 32'(i);

        vecs[0] = '{32'h08, 32'h0800_0040, 1'b1, 32'h100,       2};
        vecs[1] = '{32'h40, 32'h0C00_0080, 1'b1, 32'h200,       2};
        vecs[2] = '{32'h10, 32'h0BFF_FFFF, 1'b1, 32'h0FFF_FFFC, 2};
        vecs[3] = '{32'h20, 32'h1000_FFFE, 1'b1, 32'h18,        2};
        vecs[4] = '{32'h20, 32'h1000_0002, 1'b0, 32'h24,        1};
        vecs[5] = '{32'h80, 32'h1400_FFFF, 1'b1, 32'h7C,        2};
        vecs[6] = '{32'h30, 32'hCBFF_FFFC, 1'b1, 32'h20,        2};
        vecs[7] = '{32'h30, 32'hC800_0010, 1'b1, 32'h70,        2};
        vecs[8] = '{32'h50, 32'h1800_8000, 1'b0, 32'h54,        1};
        vecs[9] = '{32'h60, 32'hCC00_0010, 1'b0, 32'h64,        1};

        // Reset holds everything quiet.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
            checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
            checkOutput("reset_inst_enable", 32'(inst_enable), 32'd0);
            checkOutput("reset_out_pc", out_pc, 32'h0);
        end

        // Straight-line code from RESET_PC, one instruction per cycle.
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
            checkOutput("seq_inst_enable", 32'(inst_enable), 32'd1);
            checkOutput("seq_inst_addr", 32'(inst_addr), 32'(c));
            checkOutput("seq_out_valid", 32'(out_valid), (c >= 2) ? 32'd1 : 32'd0);
            if (c >= 2) begin
                checkOutput("seq_out_pc", out_pc, 32'(4 * (c - 2)));
                checkOutput("seq_out_command", out_command, 32'(c - 2));
                checkOutput("seq_pred_taken", 32'(out_pred_taken), 32'd0);
            end
        end

        // Predecode table: redirect onto the branch, then measure what follows.
        for (int i = 0; i < 10; i++) begin
            v = vecs[i];
            imem[v.br_pc[13:2]] = v.word;
            applyStimulus(1'b1, 1'b1, v.br_pc, 1'b1);
            checkOutput("vec_redirect_valid", 32'(out_valid), 32'd0);
            checkOutput("vec_redirect_addr", 32'(inst_addr), 32'(v.br_pc[17:2]));
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
            checkOutput("vec_cycle1_valid", 32'(out_valid), 32'd0);
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
            checkOutput("vec_branch_valid", 32'(out_valid), 32'd1);
            checkOutput("vec_branch_pc", out_pc, v.br_pc);
            checkOutput("vec_branch_command", out_command, v.word);
            checkOutput("vec_pred_taken", 32'(out_pred_taken), 32'(v.exp_taken));
            found   = 1'b0;
            gap     = 0;
            next_pc = 32'h0;
            for (int k = 1; k <= 4; k++) begin
                if (!found) begin
                    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
                    if (out_valid) begin
                        found   = 1'b1;
                        gap     = k;
                        next_pc = out_pc;
                    end
                end
            end
            checkOutput("vec_next_found", 32'(found), 32'd1);
            checkOutput("vec_next_gap", 32'(gap), 32'(v.exp_gap));
            checkOutput("vec_next_pc", next_pc, v.exp_next);
            imem[v.br_pc[13:2]] = 32'(v.br_pc[13:2]);
        end

        // Back-pressure: queue fills to DEPTH and issue stops.
        applyStimulus(1'b1, 1'b1, 32'h200, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("full_inst_enable", 32'(inst_enable), 32'd0);
        checkOutput("full_out_valid", 32'(out_valid), 32'd1);
        checkOutput("full_out_pc", out_pc, 32'h200);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("pop_out_pc", out_pc, 32'h200);
        checkOutput("pop_inst_enable", 32'(inst_enable), 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("refill_inst_enable", 32'(inst_enable), 32'd1);
        checkOutput("refill_inst_addr", 32'(inst_addr), 32'h84);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("refill_stop_1", 32'(inst_enable), 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("refill_stop_2", 32'(inst_enable), 32'd0);
        checkOutput("refill_head_pc", out_pc, 32'h204);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
            checkOutput("drain_valid", 32'(out_valid), 32'd1);
            checkOutput("drain_pc", out_pc, 32'h204 + 32'(4 * i));
        end

        // Redirect while queue + in-flight fetch occupy every slot.
        applyStimulus(1'b1, 1'b1, 32'h300, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("prefill_head_pc", out_pc, 32'h300);
        applyStimulus(1'b1, 1'b1, 32'h1003, 1'b1);
        checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
        checkOutput("flush_inst_enable", 32'(inst_enable), 32'd1);
        checkOutput("flush_inst_addr", 32'(inst_addr), 32'h400);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("flush_t1_valid", 32'(out_valid), 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("flush_t2_valid", 32'(out_valid), 32'd1);
        checkOutput("flush_t2_pc", out_pc, 32'h1000);
        checkOutput("flush_t2_command", out_command, 32'h400);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("flush_t3_pc", out_pc, 32'h1004);

        // Redirect arrives in the same cycle as a predicted-taken J response.
        imem[2] = 32'h0800_0040;
        bad_fetch = 1'b0;
        applyStimulus(1'b1, 1'b1, 32'h8, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h2000, 1'b1);
        checkOutput("jredir_valid", 32'(out_valid), 32'd0);
        checkOutput("jredir_addr", 32'(inst_addr), 32'h800);
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
            if (inst_enable && (inst_addr == 16'h0040)) bad_fetch = 1'b1;
            if (out_valid && ((out_pc == 32'h8) || (out_pc == 32'h100))) bad_fetch = 1'b1;
            if (k == 1) checkOutput("jredir_t1_valid", 32'(out_valid), 32'd0);
            if (k == 2) checkOutput("jredir_t2_pc", out_pc, 32'h2000);
            if (k == 3) checkOutput("jredir_t3_pc", out_pc, 32'h2004);
        end
        checkOutput("jredir_no_stale", 32'(bad_fetch), 32'd0);
        imem[2] = 32'h2;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
